// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared constants for the 68000 bus target.
// Latency: none; this file only holds constants.
// Backpressure: none.
// Contents: synchroniser depth and the encoding of the target FSM states.
package m68k_bus_pkg;

  localparam int SYNC_DEPTH = 3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DS   = 3'd1;
  localparam logic [2:0] ST_WAIT      = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_BERR_WAIT = 3'd4;
  localparam logic [2:0] ST_BERR_HOLD = 3'd5;
  localparam logic [2:0] ST_IGNORE    = 3'd6;

endpackage

// File: rtl/m68k_sync_edge.sv
// m68k_sync_edge: N-flop synchroniser with rise/fall pulses for one async bus signal.
// Latency: q follows d after N-1 c200m edges; rise/fall pulse one cycle wide, aligned with the q change.
// Backpressure: none; free-running.
// Ports: clk/rst_n (async active-low), d (async in), q (synchronised), rise/fall (single-cycle pulses).
module m68k_sync_edge #(
  parameter int   N       = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // stage[0] is the metastability-catching flop; stage[N-1] is a one-cycle
  // delayed copy of q used only for edge detection.
  logic [N-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage <= {N{RST_VAL}};
    else        stage <= {stage[N-2:0], d};
  end

  assign q    = stage[N-2];
  assign fall = stage[N-1] & ~stage[N-2];
  assign rise = ~stage[N-1] & stage[N-2];

endmodule

// File: rtl/m68k_bus_target.sv
// m68k_bus_target: 68000 async-bus responder decoding one window onto a 2^ADDR_W x 16 register file.
// Latency: DTACK 5 c200m cycles after AS low (read) or first DS low (write), plus one M68K_CLK fall per wait state.
// Backpressure: the master is stalled by withholding DTACK; unmapped cycles end in BERR (or are ignored).
// Ports: c200m/reset_n; M68K_* bus inputs (A, AS_n, UDS_n, LDS_n, RW, RESET_n, CLK) and d_in;
//        d_out/d_oe read data, M68K_DTACK_n/M68K_BERR_n handshake, acc_cnt completed cycles, busy.
module m68k_bus_target
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR    = 24'hE80000,
  parameter int          ADDR_W       = 5,
  parameter int          WAIT_STATES  = 0,
  parameter bit          BERR_EN      = 1'b1,
  parameter int          BERR_TIMEOUT = 16
) (
  input  logic        c200m,
  input  logic        reset_n,
  input  logic        M68K_CLK,
  input  logic [23:1] M68K_A,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic        M68K_RESET_n,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        d_oe,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic [15:0] acc_cnt,
  output logic        busy
);

  localparam logic [7:0] WS_LOAD   = 8'(WAIT_STATES);
  localparam logic [7:0] BERR_LOAD = 8'(BERR_TIMEOUT);

  // ---------------------------------------------------------------- sync
  logic clk_q, clk_rise, clk_fall;
  logic as_q, as_rise, as_fall;
  logic uds_q, uds_rise, uds_fall;
  logic lds_q, lds_rise, lds_fall;
  logic brst_q, brst_rise, brst_fall;

  // AS and bus reset come out of reset as "asserted" so that a strobe that is
  // really low across a reset is never mistaken for a fresh cycle.
  m68k_sync_edge #(.N(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_clk (
    .clk(c200m), .rst_n(reset_n), .d(M68K_CLK),
    .q(clk_q), .rise(clk_rise), .fall(clk_fall));
  m68k_sync_edge #(.N(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_as (
    .clk(c200m), .rst_n(reset_n), .d(M68K_AS_n),
    .q(as_q), .rise(as_rise), .fall(as_fall));
  m68k_sync_edge #(.N(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_uds (
    .clk(c200m), .rst_n(reset_n), .d(M68K_UDS_n),
    .q(uds_q), .rise(uds_rise), .fall(uds_fall));
  m68k_sync_edge #(.N(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_lds (
    .clk(c200m), .rst_n(reset_n), .d(M68K_LDS_n),
    .q(lds_q), .rise(lds_rise), .fall(lds_fall));
  m68k_sync_edge #(.N(SYNC_DEPTH), .RST_VAL(1'b0)) u_sync_rst (
    .clk(c200m), .rst_n(reset_n), .d(M68K_RESET_n),
    .q(brst_q), .rise(brst_rise), .fall(brst_fall));

  logic unused_sync;
  assign unused_sync = ^{clk_q, clk_rise, as_rise, as_fall, uds_rise, uds_fall,
                         lds_rise, lds_fall, brst_rise, brst_fall};

  // -------------------------------------------------------------- decode
  // Address/RW/data are sampled only once the synchronised strobes say the
  // master holds them stable, so they are used straight off the pins.
  logic hit;
  assign hit = (M68K_A[23:ADDR_W+1] == BASE_ADDR[23:ADDR_W+1]);

  // ---------------------------------------------------------------- state
  logic [2:0]        state;
  logic [7:0]        cnt;
  logic              armed;   // AS seen high in IDLE since the last cycle began
  logic              rw_l;
  logic              uds_l, lds_l;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       din_l;
  logic [15:0]       mem [2**ADDR_W];

  // ACK entry: wait count exhausted, AS still low and no bus reset pending.
  logic ack_entry;
  logic mem_we;
  always_comb begin
    ack_entry = (state == ST_WAIT) && (cnt == 8'd0) && !as_q && brst_q;
    mem_we    = ack_entry && !rw_l;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge c200m or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      armed        <= 1'b0;
      rw_l         <= 1'b1;
      uds_l        <= 1'b1;
      lds_l        <= 1'b1;
      idx          <= '0;
      din_l        <= 16'h0000;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
      d_oe         <= 1'b0;
      d_out        <= 16'h0000;
      acc_cnt      <= 16'h0000;
    end else if (!brst_q) begin
      // Bus reset: drop everything; AS must be seen high again before a new cycle.
      state        <= ST_IDLE;
      armed        <= 1'b0;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
      d_oe         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (as_q) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            rw_l  <= M68K_RW;
            idx   <= M68K_A[ADDR_W:1];
            if (hit) begin
              state <= ST_WAIT_DS;
            end else if (BERR_EN) begin
              state <= ST_BERR_WAIT;
              cnt   <= BERR_LOAD;
            end else begin
              state <= ST_IGNORE;
            end
          end
        end
        ST_WAIT_DS: begin
          if (as_q) begin
            state <= ST_IDLE;
          end else if (rw_l || !uds_q || !lds_q) begin
            uds_l <= uds_q;
            lds_l <= lds_q;
            din_l <= d_in;
            cnt   <= WS_LOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (as_q) begin
            state <= ST_IDLE;
          end else if (ack_entry) begin
            state        <= ST_ACK;
            M68K_DTACK_n <= 1'b0;
            acc_cnt      <= acc_cnt + 16'd1;
            if (rw_l) begin
              d_out <= mem[idx];
              d_oe  <= 1'b1;
            end
          end else if (clk_fall) begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_ACK: begin
          if (as_q) begin
            M68K_DTACK_n <= 1'b1;
            d_oe         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_BERR_WAIT: begin
          if (as_q) begin
            state <= ST_IDLE;
          end else if (cnt == 8'd0) begin
            M68K_BERR_n <= 1'b0;
            state       <= ST_BERR_HOLD;
          end else if (clk_fall) begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_BERR_HOLD: begin
          if (as_q) begin
            M68K_BERR_n <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_IGNORE: begin
          if (as_q) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register file: deliberately not reset; byte lanes follow the latched strobes.
  always_ff @(posedge c200m) begin
    if (mem_we) begin
      if (!uds_l) mem[idx][15:8] <= din_l[15:8];
      if (!lds_l) mem[idx][7:0]  <= din_l[7:0];
    end
  end

endmodule

// File: tb/tb_m68k_bus_target.sv
// tb_m68k_bus_target: randomized scoreboard bench for two target instances (0 and 3 wait states).
// Latency: not applicable.
// Backpressure: the bench master holds each cycle until DTACK/BERR or a chosen abort point.
module tb_m68k_bus_target;

  localparam logic [23:0] BASE = 24'hE80000;

  logic c200m = 1'b0;
  logic bus_clk = 1'b0;
  always #5 c200m = ~c200m;
  always #70 bus_clk = ~bus_clk;

  logic        rst_n   [2];
  logic [23:1] a       [2];
  logic        as_n    [2];
  logic        uds_n   [2];
  logic        lds_n   [2];
  logic        rw      [2];
  logic        brst_n  [2];
  logic [15:0] din     [2];
  logic [15:0] dout    [2];
  logic        doe     [2];
  logic        dtack_n [2];
  logic        berr_n  [2];
  logic [15:0] acc     [2];
  logic        busy    [2];

  m68k_bus_target #(.BASE_ADDR(BASE), .ADDR_W(5), .WAIT_STATES(0), .BERR_EN(1'b1),
                    .BERR_TIMEOUT(16)) dut0 (
    .c200m(c200m), .reset_n(rst_n[0]), .M68K_CLK(bus_clk), .M68K_A(a[0]),
    .M68K_AS_n(as_n[0]), .M68K_UDS_n(uds_n[0]), .M68K_LDS_n(lds_n[0]), .M68K_RW(rw[0]),
    .M68K_RESET_n(brst_n[0]), .d_in(din[0]), .d_out(dout[0]), .d_oe(doe[0]),
    .M68K_DTACK_n(dtack_n[0]), .M68K_BERR_n(berr_n[0]), .acc_cnt(acc[0]), .busy(busy[0]));

  m68k_bus_target #(.BASE_ADDR(BASE), .ADDR_W(5), .WAIT_STATES(3), .BERR_EN(1'b0),
                    .BERR_TIMEOUT(16)) dut1 (
    .c200m(c200m), .reset_n(rst_n[1]), .M68K_CLK(bus_clk), .M68K_A(a[1]),
    .M68K_AS_n(as_n[1]), .M68K_UDS_n(uds_n[1]), .M68K_LDS_n(lds_n[1]), .M68K_RW(rw[1]),
    .M68K_RESET_n(brst_n[1]), .d_in(din[1]), .d_out(dout[1]), .d_oe(doe[1]),
    .M68K_DTACK_n(dtack_n[1]), .M68K_BERR_n(berr_n[1]), .acc_cnt(acc[1]), .busy(busy[1]));

  // ------------------------------------------------------------ model
  typedef struct {
    bit          berr;
    bit          rd;
    logic [15:0] data;
    logic [15:0] cnt;
    int          falls;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mem_m [2][32];
  logic [15:0] cnt_m [2];
  int          st_cyc [2];
  int          st_fall [2];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bus_falls = 0;
  bit          mon_en = 1'b0;
  logic        prev_dt [2];
  logic        prev_be [2];

  always @(posedge c200m) cyc <= cyc + 1;
  always @(negedge bus_clk) bus_falls <= bus_falls + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input int d, input bit is_berr);
    exp_t e;
    int   lat;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s dut%0d: response seen with no cycle outstanding",
               is_berr ? "berr" : "dtack", d);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("kind_berr dut%0d", d), 32'(is_berr), 32'(e.berr));
    chk($sformatf("bus_falls dut%0d", d), 32'(bus_falls - st_fall[d]), 32'(e.falls));
    chk($sformatf("acc_cnt dut%0d", d), 32'(acc[d]), 32'(e.cnt));
    if (is_berr) begin
      chk($sformatf("dtack_in_berr dut%0d", d), 32'(dtack_n[d]), 32'd1);
    end else begin
      if (d == 0) begin
        lat = cyc - st_cyc[d];
        checks++;
        if (lat < 1 || lat > 5) begin
          errors++;
          $display("FAIL latency dut0: got %0d cycles required 1..5", lat);
        end
      end
      if (e.rd) begin
        chk($sformatf("rd_data dut%0d", d), 32'(dout[d]), 32'(e.data));
        chk($sformatf("d_oe_rd dut%0d", d), 32'(doe[d]), 32'd1);
      end else begin
        chk($sformatf("d_oe_wr dut%0d", d), 32'(doe[d]), 32'd0);
      end
    end
  endtask

  // Monitor: every DTACK or BERR falling edge consumes one expectation.
  always @(negedge c200m) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_en) begin
        if (prev_dt[d] === 1'b1 && dtack_n[d] === 1'b0) check_resp(d, 1'b0);
        if (prev_be[d] === 1'b1 && berr_n[d] === 1'b0) check_resp(d, 1'b1);
      end
      prev_dt[d] = dtack_n[d];
      prev_be[d] = berr_n[d];
    end
  end

  // ----------------------------------------------------------- master
  task automatic start_cycle(input int d, input logic [23:0] addr, input bit rd,
                             input logic [1:0] lanes, input logic [15:0] wdat, input bit expect_resp);
    exp_t e;
    bit   hit;
    int   idx;
    @(posedge bus_clk);
    #1;
    hit = (addr >= BASE) && (addr < BASE + 24'd64);
    a[d]   = addr[23:1];
    rw[d]  = rd;
    din[d] = rd ? 16'h0000 : wdat;
    st_cyc[d]  = cyc;
    st_fall[d] = bus_falls;
    if (expect_resp && hit) begin
      idx     = int'((addr - BASE) >> 1);
      e.berr  = 1'b0;
      e.rd    = rd;
      e.falls = (d == 0) ? 0 : 3;
      e.data  = 16'h0000;
      if (rd) begin
        e.data = mem_m[d][idx];
      end else begin
        if (lanes[1]) mem_m[d][idx][15:8] = wdat[15:8];
        if (lanes[0]) mem_m[d][idx][7:0]  = wdat[7:0];
      end
      cnt_m[d] = cnt_m[d] + 16'd1;
      e.cnt    = cnt_m[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end else if (expect_resp && d == 0) begin
      e.berr  = 1'b1;
      e.rd    = rd;
      e.data  = 16'h0000;
      e.cnt   = cnt_m[d];
      e.falls = 16;
      q0.push_back(e);
    end
    as_n[d]  = 1'b0;
    uds_n[d] = rd ? 1'b0 : ~lanes[1];
    lds_n[d] = rd ? 1'b0 : ~lanes[0];
  endtask

  task automatic wait_resp(input int d);
    int n = 0;
    while (dtack_n[d] && berr_n[d] && n < 4000) begin
      @(negedge c200m);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: no DTACK or BERR within 4000 cycles", d);
    end
    repeat (2) @(negedge c200m);
  endtask

  task automatic end_cycle(input int d);
    int n = 0;
    as_n[d]  = 1'b1;
    uds_n[d] = 1'b1;
    lds_n[d] = 1'b1;
    @(negedge c200m);
    while ((!dtack_n[d] || !berr_n[d] || busy[d]) && n < 200) begin
      @(negedge c200m);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL release dut%0d: target did not return idle dtack=%b berr=%b busy=%b",
               d, dtack_n[d], berr_n[d], busy[d]);
    end
    repeat (4) @(posedge c200m);
  endtask

  // Full cycle; dut1 ignores unmapped cycles, so those are held a while and checked as busy.
  task automatic bus_cycle(input int d, input logic [23:0] addr, input bit rd,
                           input logic [1:0] lanes, input logic [15:0] wdat);
    bit hit;
    hit = (addr >= BASE) && (addr < BASE + 24'd64);
    start_cycle(d, addr, rd, lanes, wdat, 1'b1);
    if (!hit && d == 1) begin
      repeat (300) @(negedge c200m);
      chk("ignore_busy", 32'(busy[1]), 32'd1);
      chk("ignore_no_ack", 32'({dtack_n[1], berr_n[1]}), 32'd3);
    end else begin
      wait_resp(d);
    end
    end_cycle(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ad;
    bit          rd;
    logic [1:0]  ln;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; as_n[d] = 1'b1; uds_n[d] = 1'b1; lds_n[d] = 1'b1;
      rw[d] = 1'b1; brst_n[d] = 1'b1; a[d] = '0; din[d] = 16'h0000; cnt_m[d] = 16'h0000;
    end
    repeat (3) @(posedge c200m);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_dtack dut%0d", d), 32'(dtack_n[d]), 32'd1);
      chk($sformatf("rst_berr dut%0d", d), 32'(berr_n[d]), 32'd1);
      chk($sformatf("rst_d_oe dut%0d", d), 32'(doe[d]), 32'd0);
      chk($sformatf("rst_d_out dut%0d", d), 32'(dout[d]), 32'd0);
      chk($sformatf("rst_acc dut%0d", d), 32'(acc[d]), 32'd0);
      chk($sformatf("rst_busy dut%0d", d), 32'(busy[d]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (6) @(posedge c200m);
    mon_en = 1'b1;

    // Preload every word of dut0 and the first eight of dut1.
    for (int i = 0; i < 32; i++) bus_cycle(0, BASE + 24'(2 * i), 1'b0, 2'b11, 16'($urandom));
    for (int i = 0; i < 8; i++)  bus_cycle(1, BASE + 24'(2 * i), 1'b0, 2'b11, 16'($urandom));

    // Read hit, byte-lane writes.
    bus_cycle(0, 24'hE80006, 1'b0, 2'b11, 16'hBEEF);
    bus_cycle(0, 24'hE80006, 1'b1, 2'b11, 16'h0000);
    bus_cycle(0, 24'hE80008, 1'b0, 2'b11, 16'h0000);
    bus_cycle(0, 24'hE80008, 1'b0, 2'b10, 16'h12AB);
    bus_cycle(0, 24'hE80008, 1'b1, 2'b11, 16'h0000);
    bus_cycle(0, 24'hE8000A, 1'b0, 2'b01, 16'h5566);
    bus_cycle(0, 24'hE8000A, 1'b1, 2'b11, 16'h0000);

    // Wait states on dut1, unmapped BERR on dut0, ignored cycle on dut1.
    bus_cycle(1, 24'hE80004, 1'b1, 2'b11, 16'h0000);
    bus_cycle(0, 24'h000100, 1'b1, 2'b11, 16'h0000);
    bus_cycle(1, 24'h000100, 1'b1, 2'b11, 16'h0000);

    // Abort a write on dut1 while it counts wait states.
    start_cycle(1, 24'hE80002, 1'b0, 2'b11, 16'hDEAD, 1'b0);
    @(negedge bus_clk);
    #20;
    chk("abort_in_wait_busy", 32'(busy[1]), 32'd1);
    end_cycle(1);
    chk("abort_acc", 32'(acc[1]), 32'(cnt_m[1]));
    chk("abort_dtack", 32'(dtack_n[1]), 32'd1);
    bus_cycle(1, 24'hE80002, 1'b1, 2'b11, 16'h0000);

    // Bus reset during ACK, with AS left low afterwards.
    start_cycle(0, 24'hE80010, 1'b1, 2'b11, 16'h0000, 1'b1);
    wait_resp(0);
    brst_n[0] = 1'b0;
    repeat (5) @(negedge c200m);
    chk("brst_dtack", 32'(dtack_n[0]), 32'd1);
    chk("brst_d_oe", 32'(doe[0]), 32'd0);
    chk("brst_busy", 32'(busy[0]), 32'd0);
    brst_n[0] = 1'b1;
    repeat (12) @(negedge c200m);
    chk("brst_stuck_as_idle", 32'(busy[0]), 32'd0);
    end_cycle(0);

    // Bus reset while BERR is held.
    start_cycle(0, 24'h001000, 1'b1, 2'b11, 16'h0000, 1'b1);
    wait_resp(0);
    brst_n[0] = 1'b0;
    repeat (5) @(negedge c200m);
    chk("brst_berr", 32'(berr_n[0]), 32'd1);
    brst_n[0] = 1'b1;
    end_cycle(0);

    // Chip reset during ACK: counter clears, register file keeps its contents.
    start_cycle(0, 24'hE80012, 1'b1, 2'b11, 16'h0000, 1'b1);
    wait_resp(0);
    rst_n[0] = 1'b0;
    #3;
    chk("arst_dtack", 32'(dtack_n[0]), 32'd1);
    chk("arst_d_oe", 32'(doe[0]), 32'd0);
    chk("arst_acc", 32'(acc[0]), 32'd0);
    cnt_m[0] = 16'h0000;
    @(negedge c200m);
    rst_n[0] = 1'b1;
    repeat (12) @(negedge c200m);
    chk("arst_stuck_as_idle", 32'(busy[0]), 32'd0);
    end_cycle(0);
    bus_cycle(0, 24'hE80006, 1'b1, 2'b11, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      ln = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) ad = {4'($urandom_range(0, 13)), 19'($urandom), 1'b0};
      else                           ad = BASE + 24'(2 * $urandom_range(0, 31));
      bus_cycle(0, ad, rd, ln, 16'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      rd = 1'($urandom_range(0, 1));
      ln = 2'($urandom_range(1, 3));
      bus_cycle(1, BASE + 24'(2 * $urandom_range(0, 7)), rd, ln, 16'($urandom));
    end

    repeat (10) @(negedge c200m);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("final_acc0", 32'(acc[0]), 32'(cnt_m[0]));
    chk("final_acc1", 32'(acc[1]), 32'(cnt_m[1]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
